argmax_sequencer: RTL
=====================

# argmax_sequencer

Controller wrapping one `serial_parallel_argmax_signed_16_inputs` datapath.
- Accepts a start command with a runtime chunk count, then streams that many 16-element signed chunks into the datapath over a valid/ready handshake.
- Clears the datapath's running state between vectors and returns the global max and argmax with a one-cycle done pulse.
- Sits between a vector source (buffer or upstream layer) and the classifier-output consumer.

## Interface
- WIDTH, 8, element width (signed)
- ARGMAX_WIDTH, 8, global index width; requires 16*max(num_chunks) <= 2^ARGMAX_WIDTH
- CNT_WIDTH, 4, width of num_chunks and internal chunk counter

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- num_chunks  in  CNT_WIDTH  chunks in this vector, latched with start
- abort  in  1  cancel current vector (active only with macro, see Configuration)
- in_valid  in  1  chunk on `in` is valid
- in_ready  out  1  sequencer accepts chunk
- in  in  16 x WIDTH signed  chunk elements, index 0..15
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result valid
- error  out  1  with done: zero-length vector requested
- max  out  WIDTH signed  held global maximum
- argmax  out  ARGMAX_WIDTH  held global index = chunk*16 + local

## Operation
States: IDLE, CLEAR, RUN, DRAIN, DONE.

- IDLE:
  - start && num_chunks != 0: latch num_chunks, zero chunk counter, go to CLEAR.
  - start && num_chunks == 0: go to DONE with error=1, max=0, argmax=0.
- CLEAR: registered clear pulse `clr_q`=1 for exactly this cycle; datapath reset = rst | clr_q (glitch-free, registered). Go to RUN.
- RUN:
  - in_ready=1; datapath enable = in_valid && in_ready.
  - Each handshake increments the counter.
  - Handshake with counter == latched_count-1: go to DRAIN.
- DRAIN: in_ready=0; datapath output settles. Register max/argmax into output holding regs; error=0. Go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Output max/argmax/error hold until the next DRAIN, the next zero-length DONE, or rst.
- start outside IDLE is ignored and not queued.
- in_valid outside RUN is not consumed; upstream holds data.
- Counter is exact: no wrap; num_chunks = 2^CNT_WIDTH-1 is legal.
- Max compare and tie policy belong to the datapath; the sequencer adds no arithmetic.

## Timing
- Reset (async): state IDLE; in_ready, busy, done, error, clr_q = 0; max = 0, argmax = 0; datapath held in reset.
- start at cycle t: CLEAR at t+1, in_ready first high at t+2.
- Last chunk handshake at cycle u: DRAIN at u+1, done high at u+2, outputs valid from u+2.
- Minimum start-to-done: num_chunks + 3 cycles with in_valid held high.
- Zero-length: start at t gives done=error=1 at t+1.
- in_valid may drop at any RUN cycle. Stalls add cycles only; no data loss.
- start may be asserted in the cycle done is high; it is ignored (state DONE), accepted the next cycle.
- rst mid-vector returns to IDLE immediately; no done; outputs to 0.

## Configuration
- ARGMAX_SEQUENCER_ABORT_EN defined: abort sampled in CLEAR, RUN and DRAIN forces IDLE next cycle.
  - No done.
  - max/argmax/error keep their previous values.
  - Datapath is cleared by the next vector's CLEAR.
  - abort in IDLE or DONE has no effect.
  - abort and in_valid in the same RUN cycle: chunk not accepted (in_ready forced 0).
- Not defined: abort port present but ignored; FSM has no abort transitions.

## Structure
- Package `argmax_sequencer_pkg`:
  - state enum (IDLE, CLEAR, RUN, DRAIN, DONE)
  - constant CHUNK_SIZE = 16
  - constant CHUNK_IDX_WIDTH = 4
- One sub-module: instance of `serial_parallel_argmax_signed_16_inputs` with WIDTH and ARGMAX_WIDTH passed through.
- FSM, counter, clear register and output holding regs are in this module.

## Test plan
- num_chunks=1, in_valid held, chunk with element 9 = 100, others distinct below 100 -> done at start+4, max=100, argmax=9, error=0.
- num_chunks=3, global max -5 at chunk 2 element 3, all other elements <= -6 -> argmax=35, max=-5 (signed compare).
- num_chunks=4 with in_valid deasserted 2 cycles before every chunk -> exactly 4 handshakes, done 2 cycles after last handshake, result matches reference model.
- Back-to-back vectors: second vector's values all below first vector's max -> second result comes from second vector only (CLEAR works); start in DONE cycle ignored.
- num_chunks=0 -> done=error=1 one cycle after start, max=0, argmax=0; start during RUN ignored.
- rst asserted mid-RUN -> outputs 0 same cycle, no done. With macro defined, abort at chunk 2 of 5 -> IDLE next cycle, no done, previous result held.

Source files
------------

// File: rtl/argmax_sequencer_pkg.sv
// Shared types and constants for the argmax sequencer and its datapath.
package argmax_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int CHUNK_SIZE      = 16;
   localparam int CHUNK_IDX_WIDTH = 4;

endpackage

// File: rtl/serial_parallel_argmax_signed_16_inputs.sv
// Running signed max/argmax over a stream of 16-element chunks: a 4-level compare
// tree finds the chunk winner, a register stage folds it into the global result.
module serial_parallel_argmax_signed_16_inputs
   import argmax_sequencer_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int ARGMAX_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic signed [WIDTH-1:0]        in [CHUNK_SIZE],
   output logic signed [WIDTH-1:0]        max,
   output logic        [ARGMAX_WIDTH-1:0] argmax
);

   logic signed [WIDTH-1:0]           s1_val [8];
   logic        [CHUNK_IDX_WIDTH-1:0] s1_idx [8];
   logic signed [WIDTH-1:0]           s2_val [4];
   logic        [CHUNK_IDX_WIDTH-1:0] s2_idx [4];
   logic signed [WIDTH-1:0]           s3_val [2];
   logic        [CHUNK_IDX_WIDTH-1:0] s3_idx [2];
   logic signed [WIDTH-1:0]           chunk_max;
   logic        [CHUNK_IDX_WIDTH-1:0] chunk_idx;

   // Ties resolve toward the lower index at every tree node.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_s1
         logic take_hi;
         assign take_hi    = in[2*gi+1] > in[2*gi];
         assign s1_val[gi] = take_hi ? in[2*gi+1] : in[2*gi];
         assign s1_idx[gi] = take_hi ? CHUNK_IDX_WIDTH'(2*gi+1) : CHUNK_IDX_WIDTH'(2*gi);
      end
      for (gi = 0; gi < 4; gi++) begin : g_s2
         logic take_hi;
         assign take_hi    = s1_val[2*gi+1] > s1_val[2*gi];
         assign s2_val[gi] = take_hi ? s1_val[2*gi+1] : s1_val[2*gi];
         assign s2_idx[gi] = take_hi ? s1_idx[2*gi+1] : s1_idx[2*gi];
      end
      for (gi = 0; gi < 2; gi++) begin : g_s3
         logic take_hi;
         assign take_hi    = s2_val[2*gi+1] > s2_val[2*gi];
         assign s3_val[gi] = take_hi ? s2_val[2*gi+1] : s2_val[2*gi];
         assign s3_idx[gi] = take_hi ? s2_idx[2*gi+1] : s2_idx[2*gi];
      end
   endgenerate

   assign chunk_max = (s3_val[1] > s3_val[0]) ? s3_val[1] : s3_val[0];
   assign chunk_idx = (s3_val[1] > s3_val[0]) ? s3_idx[1] : s3_idx[0];

   logic signed [WIDTH-1:0]        max_reg;
   logic        [ARGMAX_WIDTH-1:0] argmax_reg;
   logic        [ARGMAX_WIDTH-1:0] base_reg;
   logic                           first_reg;

   // The first chunk after reset seeds the result, so all-negative vectors work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_reg    <= '0;
         argmax_reg <= '0;
         base_reg   <= '0;
         first_reg  <= 1'b1;
      end else if (en) begin
         base_reg  <= base_reg + ARGMAX_WIDTH'(CHUNK_SIZE);
         first_reg <= 1'b0;
         if (first_reg || (chunk_max > max_reg)) begin
            max_reg    <= chunk_max;
            argmax_reg <= base_reg + ARGMAX_WIDTH'(chunk_idx);
         end
      end
   end

   assign max    = max_reg;
   assign argmax = argmax_reg;

endmodule

// File: rtl/argmax_sequencer.sv
// Sequences chunked vectors through the argmax datapath and holds the result.
// Optional build macro ARGMAX_SEQUENCER_ABORT_EN enables the abort input.
module argmax_sequencer
   import argmax_sequencer_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int ARGMAX_WIDTH = 8,
   parameter int CNT_WIDTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic        [CNT_WIDTH-1:0]    num_chunks,
   input  logic                           abort,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [WIDTH-1:0]        in [CHUNK_SIZE],
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic signed [WIDTH-1:0]        max,
   output logic        [ARGMAX_WIDTH-1:0] argmax
);

   state_t                         state_reg, state_next;
   logic        [CNT_WIDTH-1:0]    count_reg;
   logic        [CNT_WIDTH-1:0]    chunk_cnt_reg;
   logic                           clr_q;
   logic signed [WIDTH-1:0]        max_reg;
   logic        [ARGMAX_WIDTH-1:0] argmax_reg;
   logic                           error_reg;
   logic                           abort_active;
   logic                           dp_en;
   logic                           dp_rst;
   logic                           last_chunk;
   logic signed [WIDTH-1:0]        dp_max;
   logic        [ARGMAX_WIDTH-1:0] dp_argmax;

`ifdef ARGMAX_SEQUENCER_ABORT_EN
   assign abort_active = abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_active = 1'b0;
`endif

   assign in_ready   = (state_reg == RUN) && !abort_active;
   assign dp_en      = in_valid && in_ready;
   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign last_chunk = (chunk_cnt_reg == count_reg - CNT_WIDTH'(1));
   // clr_q comes straight from a flop, so the OR cannot glitch on clr_q's side.
   assign dp_rst     = rst | clr_q;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = (num_chunks == '0) ? DONE : CLEAR;
         CLEAR:   state_next = RUN;
         RUN:     if (dp_en && last_chunk) state_next = DRAIN;
         DRAIN:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
`ifdef ARGMAX_SEQUENCER_ABORT_EN
      if (abort && (state_reg == CLEAR || state_reg == RUN || state_reg == DRAIN))
         state_next = IDLE;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         clr_q         <= 1'b0;
         count_reg     <= '0;
         chunk_cnt_reg <= '0;
         max_reg       <= '0;
         argmax_reg    <= '0;
         error_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         clr_q     <= (state_next == CLEAR);
         if (state_reg == IDLE && start) begin
            count_reg     <= num_chunks;
            chunk_cnt_reg <= '0;
            if (num_chunks == '0) begin
               max_reg    <= '0;
               argmax_reg <= '0;
               error_reg  <= 1'b1;
            end
         end
         if (dp_en)
            chunk_cnt_reg <= chunk_cnt_reg + CNT_WIDTH'(1);
         // An aborted DRAIN leaves the previous result in place.
         if (state_reg == DRAIN && state_next == DONE) begin
            max_reg    <= dp_max;
            argmax_reg <= dp_argmax;
            error_reg  <= 1'b0;
         end
      end
   end

   assign max    = max_reg;
   assign argmax = argmax_reg;
   assign error  = error_reg;

   serial_parallel_argmax_signed_16_inputs #(
      .WIDTH        (WIDTH),
      .ARGMAX_WIDTH (ARGMAX_WIDTH)
   ) u_datapath (
      .clk    (clk),
      .rst    (dp_rst),
      .en     (dp_en),
      .in     (in),
      .max    (dp_max),
      .argmax (dp_argmax)
   );

endmodule
